axi_store_scheduler: RTL and testbench

- Sits between the core's store path and the AXI4 write channels of the data-memory interconnect.
- Accepts SB/SH/SW store requests, performs byte-lane alignment and WSTRB generation, and buffers requests in a small FIFO.
- Sequences one single-beat AXI write at a time: AW and W issued together, then waits for B.
- Stalls the core when the buffer is full; flags misaligned stores and bus errors.

---
 rtl/store_axi_pkg.sv | 24 ++
 rtl/store_req_fifo.sv | 59 +++++
 rtl/axi_store_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_axi_store_scheduler.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_axi_pkg.sv
// Shared types and constants for the store-to-AXI write scheduler.
package store_axi_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RESP
    } sched_state_t;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/store_req_fifo.sv
// Synchronous FIFO of aligned store entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module store_req_fifo
    import store_axi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  store_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output store_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    store_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_store_scheduler.sv
// Aligns SB/SH/SW stores, buffers them and issues single-beat AXI4 writes one at a time.
// Define STORE_ERR_CNT_EN to add saturating error / misalign counters.
//
// state | meaning
// IDLE  | waiting for a buffered store; loads head into AW/W registers
// SEND  | AW and W valid, each dropped independently after its handshake
// RESP  | BREADY high, waiting for BVALID; pops the entry on completion
module axi_store_scheduler
    import store_axi_pkg::*;
#(
    parameter int                  DEPTH    = 2,
    parameter int                  ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = ID_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                store_req,
    input  logic [31:0]         store_addr,
    input  logic [2:0]          store_funct3,
    input  logic [31:0]         store_data,
    output logic                store_stall,
    output logic                store_misalign,
    output logic                bus_error,
    output logic                idle,
`ifdef STORE_ERR_CNT_EN
    output logic [7:0]          err_count,
    output logic [7:0]          misalign_count,
`endif
    output logic [ID_WIDTH-1:0] AWID,
    output logic [31:0]         AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [31:0]         WDATA,
    output logic [3:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_WIDTH-1:0] BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY
);

    sched_state_t state, state_nxt;
    store_entry_t push_entry;
    store_entry_t head;
    logic         misaligned;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         err_set;

    logic         aw_valid_q, aw_valid_nxt;
    logic         w_valid_q, w_valid_nxt;
    logic         bready_q, bready_nxt;
    logic [31:0]  awaddr_q, awaddr_nxt;
    logic [31:0]  wdata_q, wdata_nxt;
    logic [3:0]   wstrb_q, wstrb_nxt;
    logic         bus_error_q;

    // Response ID is not checked and funct3[2] does not select a store width.
    logic unused_inputs;
    assign unused_inputs = ^{BID, store_funct3[2]};

    assign misaligned = (store_funct3[1:0] == 2'b11)
                      | ((store_funct3[1:0] == F3_SH[1:0]) & store_addr[0])
                      | ((store_funct3[1:0] == F3_SW[1:0]) & (store_addr[1:0] != 2'b00));

    assign store_misalign = store_req & misaligned;
    assign store_stall    = store_req & ~misaligned & full;
    assign push           = store_req & ~misaligned & ~full;

    always_comb begin
        push_entry      = '0;
        push_entry.addr = {store_addr[31:2], 2'b00};
        case (store_funct3[1:0])
            F3_SB[1:0]: begin
                push_entry.strb = 4'b0001 << store_addr[1:0];
                push_entry.data = {24'b0, store_data[7:0]} << {store_addr[1:0], 3'b000};
            end
            F3_SH[1:0]: begin
                push_entry.strb = store_addr[1] ? 4'b1100 : 4'b0011;
                push_entry.data = store_addr[1] ? {store_data[15:0], 16'b0}
                                                : {16'b0, store_data[15:0]};
            end
            default: begin
                push_entry.strb = 4'b1111;
                push_entry.data = store_data;
            end
        endcase
    end

    store_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    always_comb begin
        state_nxt    = state;
        aw_valid_nxt = aw_valid_q;
        w_valid_nxt  = w_valid_q;
        bready_nxt   = bready_q;
        awaddr_nxt   = awaddr_q;
        wdata_nxt    = wdata_q;
        wstrb_nxt    = wstrb_q;
        pop          = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    awaddr_nxt   = head.addr;
                    wdata_nxt    = head.data;
                    wstrb_nxt    = head.strb;
                    aw_valid_nxt = 1'b1;
                    w_valid_nxt  = 1'b1;
                    state_nxt    = SEND;
                end
            end
            SEND: begin
                if (AWREADY) aw_valid_nxt = 1'b0;
                if (WREADY)  w_valid_nxt  = 1'b0;
                // A channel whose valid is already low has completed its handshake.
                if ((!aw_valid_q || AWREADY) && (!w_valid_q || WREADY)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (BVALID) begin
                    pop        = 1'b1;
                    bready_nxt = 1'b0;
                    err_set    = (BRESP != AXI_RESP_OKAY);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            aw_valid_q  <= aw_valid_nxt;
            w_valid_q   <= w_valid_nxt;
            bready_q    <= bready_nxt;
            awaddr_q    <= awaddr_nxt;
            wdata_q     <= wdata_nxt;
            wstrb_q     <= wstrb_nxt;
            bus_error_q <= bus_error_q | err_set;
        end
    end

`ifdef STORE_ERR_CNT_EN
    logic [7:0] err_count_q;
    logic [7:0] misalign_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q      <= '0;
            misalign_count_q <= '0;
        end else begin
            if (err_set && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
            if (store_misalign && (misalign_count_q != 8'hFF)) begin
                misalign_count_q <= misalign_count_q + 8'd1;
            end
        end
    end

    assign err_count      = err_count_q;
    assign misalign_count = misalign_count_q;
`endif

    assign idle      = empty & (state == IDLE);
    assign bus_error = bus_error_q;
    assign AWID      = AXI_ID;
    assign AWADDR    = awaddr_q;
    assign AWLEN     = 8'd0;
    assign AWSIZE    = AXI_SIZE_WORD;
    assign AWBURST   = AXI_BURST_INCR;
    assign AWVALID   = aw_valid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = 1'b1;
    assign WVALID    = w_valid_q;
    assign BREADY    = bready_q;

endmodule

// File: tb/tb_axi_store_scheduler.sv
// Scoreboard bench: accepted stores push expected AXI writes; a negedge monitor
// checks each completed AW+W pair, channel stability and response bookkeeping.
module tb_axi_store_scheduler;
    import store_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_req;
    logic [31:0] store_addr;
    logic [2:0]  store_funct3;
    logic [31:0] store_data;
    logic        store_stall, store_misalign, bus_error, idle;
`ifdef STORE_ERR_CNT_EN
    logic [7:0]  err_count, misalign_count;
`endif
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;

    axi_store_scheduler #(.DEPTH(2), .ID_WIDTH(4), .AXI_ID(4'h1)) dut (
        .clk(clk), .rst(rst),
        .store_req(store_req), .store_addr(store_addr), .store_funct3(store_funct3),
        .store_data(store_data), .store_stall(store_stall), .store_misalign(store_misalign),
        .bus_error(bus_error), .idle(idle),
`ifdef STORE_ERR_CNT_EN
        .err_count(err_count), .misalign_count(misalign_count),
`endif
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    store_entry_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Responder: AWREADY level, WREADY after w_delay cycles of WVALID, BVALID b_delay after BREADY.
    logic       aw_en = 1'b1;
    int         w_delay = 0;
    int         b_delay = 2;
    logic [1:0] bresp_cfg = 2'b00;
    int         w_cnt = 0;
    int         bwait = 0;

    always begin
        @(posedge clk);
        #1;
        AWREADY = aw_en;
        if (WVALID) w_cnt++; else w_cnt = 0;
        WREADY = WVALID && (w_cnt > w_delay);
        if (rst) begin
            BVALID = 1'b0;
            bwait  = 0;
        end else if (BVALID) begin
            BVALID = 1'b0;
        end else if (BREADY) begin
            if (bwait >= b_delay) begin
                BVALID = 1'b1;
                BRESP  = bresp_cfg;
                bwait  = 0;
            end else begin
                bwait++;
            end
        end
    end

    // Monitor
    logic        aw_cap = 1'b0, w_cap = 1'b0;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;
    logic        aw_hold = 1'b0, w_hold = 1'b0;
    logic [31:0] aw_hold_addr, w_hold_data;
    logic [3:0]  w_hold_strb;
    time         aw_hs_time, w_hs_time;
    int          b_count = 0;

    always @(negedge clk) begin
        if (rst) begin
            aw_cap  = 1'b0;
            w_cap   = 1'b0;
            aw_hold = 1'b0;
            w_hold  = 1'b0;
        end else begin
            if (aw_hold) begin
                chk("awvalid_held", {31'b0, AWVALID}, 32'd1);
                chk("awaddr_stable", AWADDR, aw_hold_addr);
            end
            if (w_hold) begin
                chk("wvalid_held", {31'b0, WVALID}, 32'd1);
                chk("wdata_stable", WDATA, w_hold_data);
                chk("wstrb_stable", {28'b0, WSTRB}, {28'b0, w_hold_strb});
            end
            aw_hold      = AWVALID && !AWREADY;
            aw_hold_addr = AWADDR;
            w_hold       = WVALID && !WREADY;
            w_hold_data  = WDATA;
            w_hold_strb  = WSTRB;
            if (AWVALID && AWREADY) begin
                aw_cap     = 1'b1;
                cap_addr   = AWADDR;
                aw_hs_time = $time;
            end
            if (WVALID && WREADY) begin
                w_cap     = 1'b1;
                cap_data  = WDATA;
                cap_strb  = WSTRB;
                w_hs_time = $time;
            end
            if (aw_cap && w_cap) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", cap_addr, cap_data);
                end else begin
                    store_entry_t e;
                    e = sb.pop_front();
                    chk("awaddr", cap_addr, e.addr);
                    chk("wstrb", {28'b0, cap_strb}, {28'b0, e.strb});
                    chk("wdata", cap_data, e.data);
                end
                aw_cap = 1'b0;
                w_cap  = 1'b0;
            end
            if (BVALID && BREADY) b_count++;
        end
    end

    // Presents a store, holding it while stalled; returns at posedge+1 after acceptance.
    task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                            input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ed,
                            output int stalls, output int bc);
        store_entry_t e;
        stalls       = 0;
        store_req    = 1'b1;
        store_addr   = a;
        store_funct3 = f3;
        store_data   = d;
        forever begin
            @(negedge clk);
            if (!store_stall) break;
            stalls++;
            if (stalls > 200) begin
                tmo("store_stall_bound");
                break;
            end
            @(posedge clk);
            #1;
        end
        e.addr = ea;
        e.strb = es;
        e.data = ed;
        sb.push_back(e);
        bc = b_count;
        @(posedge clk);
        #1;
        store_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!idle) begin
            k++;
            if (k > 300) begin
                tmo(name);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st1, st2, st3, bc1, bc2, bc3, b0, k;
        rst = 1'b1;
        store_req = 1'b0;
        store_addr = '0;
        store_funct3 = '0;
        store_data = '0;
        AWREADY = 1'b0;
        WREADY = 1'b0;
        BVALID = 1'b0;
        BRESP = 2'b00;
        BID = 4'h7;

        // Reset state and constant channel fields
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awvalid", {31'b0, AWVALID}, 32'd0);
        chk("rst_wvalid", {31'b0, WVALID}, 32'd0);
        chk("rst_bready", {31'b0, BREADY}, 32'd0);
        chk("rst_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_idle", {31'b0, idle}, 32'd1);
        chk("rst_awaddr", AWADDR, 32'd0);
        chk("rst_wdata", WDATA, 32'd0);
        chk("rst_wstrb", {28'b0, WSTRB}, 32'd0);
        chk("awlen", {24'b0, AWLEN}, 32'd0);
        chk("awsize", {29'b0, AWSIZE}, 32'd2);
        chk("awburst", {30'b0, AWBURST}, 32'd1);
        chk("wlast", {31'b0, WLAST}, 32'd1);
        chk("awid", {28'b0, AWID}, 32'd1);
`ifdef STORE_ERR_CNT_EN
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        chk("rst_misalign_count", {24'b0, misalign_count}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SB to the top byte lane; idle must return right after B
        b0 = b_count;
        do_store(32'h1003, F3_SB, 32'h0000_00A5, 32'h1000, 4'b1000, 32'hA500_0000, st1, bc1);
        k = 0;
        while (b_count == b0) begin
            @(negedge clk);
            k++;
            if (k > 100) begin
                tmo("sb_bresp_wait");
                break;
            end
        end
        @(negedge clk);
        chk("idle_after_b", {31'b0, idle}, 32'd1);
        @(posedge clk);
        #1;

        // SH upper half with W delayed behind AW
        w_delay = 3;
        do_store(32'h2002, F3_SH, 32'h0000_1234, 32'h2000, 4'b1100, 32'h1234_0000, st1, bc1);
        wait_idle("sh_idle");
        chk("aw_before_w", {31'b0, (aw_hs_time < w_hs_time)}, 32'd1);
        w_delay = 0;

        // SB / SH to lower lanes
        do_store(32'h1001, F3_SB, 32'hFFFF_FF3C, 32'h1000, 4'b0010, 32'h0000_3C00, st1, bc1);
        wait_idle("sb1_idle");
        do_store(32'h2000, F3_SH, 32'hAAAA_BEEF, 32'h2000, 4'b0011, 32'h0000_BEEF, st1, bc1);
        wait_idle("sh0_idle");

        // Three back-to-back SW into a two-entry buffer with AW blocked
        aw_en = 1'b0;
        b0 = b_count;
        fork
            begin
                do_store(32'h4000, F3_SW, 32'h1111_1111, 32'h4000, 4'b1111, 32'h1111_1111, st1, bc1);
                do_store(32'h4004, F3_SW, 32'h2222_2222, 32'h4004, 4'b1111, 32'h2222_2222, st2, bc2);
                do_store(32'h4008, F3_SW, 32'h3333_3333, 32'h4008, 4'b1111, 32'h3333_3333, st3, bc3);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                aw_en = 1'b1;
            end
        join
        chk("first_no_stall", st1, 32'd0);
        chk("second_no_stall", st2, 32'd0);
        chk("third_stalled", {31'b0, (st3 > 0)}, 32'd1);
        chk("stall_until_b", {31'b0, (bc3 > b0)}, 32'd1);
        wait_idle("sw3_idle");
        chk("sw3_drained", sb.size(), 32'd0);

        // Misaligned SW is dropped without stalling
        store_req = 1'b1;
        store_addr = 32'h3001;
        store_funct3 = F3_SW;
        store_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("misalign_pulse", {31'b0, store_misalign}, 32'd1);
        chk("misalign_no_stall", {31'b0, store_stall}, 32'd0);
        @(posedge clk);
        #1;
        store_req = 1'b0;
        @(negedge clk);
        chk("misalign_clear", {31'b0, store_misalign}, 32'd0);
        repeat (3) @(negedge clk);
        chk("misalign_no_aw", {31'b0, AWVALID}, 32'd0);
        chk("misalign_idle", {31'b0, idle}, 32'd1);
`ifdef STORE_ERR_CNT_EN
        chk("misalign_count", {24'b0, misalign_count}, 32'd1);
`endif
        @(posedge clk);
        #1;

        // SLVERR response sets sticky bus_error; next store completes normally
        bresp_cfg = 2'b10;
        do_store(32'h5000, F3_SW, 32'hDEAD_BEEF, 32'h5000, 4'b1111, 32'hDEAD_BEEF, st1, bc1);
        wait_idle("err_idle");
        chk("bus_error_set", {31'b0, bus_error}, 32'd1);
        bresp_cfg = 2'b00;
        do_store(32'h5004, F3_SW, 32'h0123_4567, 32'h5004, 4'b1111, 32'h0123_4567, st1, bc1);
        wait_idle("after_err_idle");
        chk("bus_error_sticky", {31'b0, bus_error}, 32'd1);
`ifdef STORE_ERR_CNT_EN
        chk("err_count", {24'b0, err_count}, 32'd1);
`endif

        // Reset while stuck in SEND
        aw_en = 1'b0;
        w_delay = 1000;
        do_store(32'h6000, F3_SW, 32'h6666_6666, 32'h6000, 4'b1111, 32'h6666_6666, st1, bc1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("send_awvalid", {31'b0, AWVALID}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        aw_en = 1'b1;
        w_delay = 0;
        @(negedge clk);
        chk("rst_mid_awvalid", {31'b0, AWVALID}, 32'd0);
        chk("rst_mid_wvalid", {31'b0, WVALID}, 32'd0);
        chk("rst_mid_idle", {31'b0, idle}, 32'd1);
        chk("rst_mid_bus_error", {31'b0, bus_error}, 32'd0);
        chk("rst_mid_bready", {31'b0, BREADY}, 32'd0);
        @(posedge clk);
        #1;

        do_store(32'h7002, F3_SB, 32'h0000_0077, 32'h7000, 4'b0100, 32'h0077_0000, st1, bc1);
        wait_idle("post_rst_idle");
        chk("final_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
